// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity
// encodings, FSM state encoding and the bit-period helper functions.
package uart_pkg;

    // Parity selection values for the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Width of the per-frame bit counter; large enough for up to 9 data bits.
    localparam int BIT_CNT_W = 4;

    // Transmitter FSM states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    // Bit period in clock cycles, rounded to the nearest integer.
    function automatic int calc_div(input longint clk_hz, input longint baud_hz);
        return int'((clk_hz + baud_hz / 2) / baud_hz);
    endfunction

    // Width of a counter that spans 0..div-1 (never narrower than one bit).
    function automatic int timer_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable bit-period timer. Counts 0..DIV-1 and wraps; a restart forces
// the count back to zero so that the following bit starts phase-aligned.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int W = timer_width(DIV);

    if (DIV < 2) begin : g_err_div
        $error("uart_bit_timer: DIV must be at least 2");
    end

    logic [W-1:0] cnt;

    // Cycle counter within the current bit, wrapping at DIV-1 or on restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || (cnt == W'(DIV - 1))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // bit_end marks the last cycle of a bit; bit_pre_end the cycle before it,
    // which lets the owner register an output that lines up with bit_end.
    assign bit_end     = (cnt == W'(DIV - 1));
    assign bit_pre_end = (cnt == W'(DIV - 2));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, none/odd/even parity and
// 1 or 2 stop bits, with a ready/valid word interface. Every output comes
// straight from a flop; next values are computed one cycle ahead.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD_HZ   = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic                 tx
);

    localparam int DIV = calc_div(CLK_HZ, BAUD_HZ);
    localparam bit HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_err_div
        $error("uart_tx_cfg: CLK_HZ/BAUD_HZ must round to at least 2");
    end

    uart_state_e            state, state_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic                   par_q, par_n;
    logic                   tx_q, tx_n;
    logic                   ready_q, ready_n;
    logic                   busy_q, busy_n;
    logic                   done_q, done_n;
    logic                   restart;
    logic                   bit_end;
    logic                   bit_pre_end;
    logic                   accept;

    uart_bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    // A word is taken only from IDLE, so anything on the input while a
    // frame is in flight is ignored.
    assign accept = (state == S_IDLE) && tx_valid && ready_q;

    // Next-state, datapath and registered-output decode for the frame FSM.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        par_n     = par_q;
        tx_n      = tx_q;
        ready_n   = ready_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE: begin
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
                if (accept) begin
                    shreg_n   = tx_data;
                    par_n     = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);
                    bit_cnt_n = '0;
                    restart   = 1'b1;
                    state_n   = S_START;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                    ready_n   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n   = S_DATA;
                    tx_n      = shreg[0];
                    bit_cnt_n = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        if (HAS_PARITY) begin
                            state_n = S_PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                        tx_n      = shreg_n[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n   = S_STOP;
                    tx_n      = 1'b1;
                    bit_cnt_n = '0;
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                // Raise frame_done so that it is high on the final stop cycle.
                if (bit_pre_end && (bit_cnt == LAST_STOP)) begin
                    done_n = 1'b1;
                end
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_n   = S_IDLE;
                        busy_n    = 1'b0;
                        ready_n   = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Control state and output flops; reset drives the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            tx_q    <= tx_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Shift register and parity bit; only meaningful once a word is accepted.
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        par_q <= par_n;
    end

    assign tx         = tx_q;
    assign tx_ready   = ready_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 7N2) at DIV=10,
// each compared cycle by cycle against a frame model built from bit-slot
// arithmetic.
module tb_uart_tx_cfg;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] bsy;
    logic [3:0] dne;
    logic [3:0] txl;
    logic [8:0] dat [4];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD_HZ(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
        .tx_ready(rdy[0]), .tx_busy(bsy[0]), .frame_done(dne[0]), .tx(txl[0]));
    uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD_HZ(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
        .tx_ready(rdy[1]), .tx_busy(bsy[1]), .frame_done(dne[1]), .tx(txl[1]));
    uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD_HZ(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
        .tx_ready(rdy[2]), .tx_busy(bsy[2]), .frame_done(dne[2]), .tx(txl[2]));
    uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD_HZ(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(dat[3][6:0]),
        .tx_ready(rdy[3]), .tx_busy(bsy[3]), .frame_done(dne[3]), .tx(txl[3]));

    function automatic int db_of(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int par_of(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int sb_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return (1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i)) * DIV;
    endfunction

    // Expected line level on cycle n (1-based) after the accepting edge.
    function automatic logic exp_bit(input int i, input logic [8:0] d, input int n);
        int slot;
        int ones;
        slot = (n - 1) / DIV;
        if (slot == 0) return 1'b0;
        slot = slot - 1;
        if (slot < db_of(i)) return d[slot];
        slot = slot - db_of(i);
        if (par_of(i) != 0 && slot == 0) begin
            ones = 0;
            for (int b = 0; b < db_of(i); b++) ones += int'(d[b]);
            if (par_of(i) == 2) return ((ones % 2) == 1);
            return ((ones % 2) == 0);
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    // Send one word on instance i and compare {tx,frame_done,tx_busy,tx_ready}
    // on every cycle through the first idle cycle. Entered and left on a
    // falling edge. With hold set, tx_valid stays high and tx_data is
    // scribbled to all ones mid-frame; otherwise both are randomised.
    task automatic run_frame(input int i, input logic [8:0] d, input bit hold);
        int len;
        logic [3:0] e;
        len = frame_len(i);
        check($sformatf("ready_before i%0d", i), 32'(rdy[i]), 32'd1);
        dat[i] = d;
        vld[i] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= len + 1; n++) begin
            @(negedge clk);
            if (n <= len) e = {exp_bit(i, d, n), (n == len), 1'b1, 1'b0};
            else          e = 4'b1001;
            check($sformatf("i%0d d%0h cyc%0d", i, d, n),
                  32'({txl[i], dne[i], bsy[i], rdy[i]}), 32'(e));
            if (n <= len) begin
                dat[i] = hold ? 9'h1FF : 9'($urandom);
                vld[i] = hold ? 1'b1 : 1'($urandom_range(0, 1));
            end else if (!hold) begin
                vld[i] = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        vld = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("in_reset i%0d", i), 32'({txl[i], dne[i], bsy[i], rdy[i]}), 32'h8);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("after_reset i%0d", i), 32'({txl[i], dne[i], bsy[i], rdy[i]}), 32'h9);

        // Idle with tx_valid low
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                check($sformatf("idle i%0d c%0d", i, c), 32'({txl[i], dne[i], bsy[i], rdy[i]}), 32'h9);
        end

        // Directed frames
        run_frame(0, 9'h055, 1'b0);
        run_frame(1, 9'h007, 1'b0);
        run_frame(2, 9'h007, 1'b0);
        run_frame(3, 9'h0FF, 1'b0);

        // Back-to-back with tx_valid held and tx_data changed mid-frame
        run_frame(0, 9'h0A5, 1'b1);
        run_frame(0, 9'h03C, 1'b0);
        run_frame(3, 9'h02A, 1'b1);
        run_frame(3, 9'h155, 1'b0);

        // Randomised frames on every configuration
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 5; k++) begin
                run_frame(i, 9'($urandom), 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        // Reset in the middle of a 0x00 frame on the 8N1 instance
        dat[0] = 9'h000;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        repeat (35) @(posedge clk);
        #1 check("pre_reset tx", 32'(txl[0]), 32'd0);
        #1 rst = 1'b1;
        #1 check("async_reset", 32'({txl[0], dne[0], bsy[0], rdy[0]}), 32'h8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("held_reset c%0d", c), 32'({txl[0], dne[0], bsy[0], rdy[0]}), 32'h8);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", 32'({txl[0], dne[0], bsy[0], rdy[0]}), 32'h9);
        run_frame(0, 9'h081, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("quiet c%0d", c), 32'({txl[0], dne[0], bsy[0], rdy[0]}), 32'h9);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Configurable UART transmitter. It is the successor to the fixed 8-N-1 transmitter and is generalised to 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. It has a ready/valid byte interface and its own restartable bit timer. It sits between the sensor packetiser and the board TX pin.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD_HZ, 115_200, line rate in bits/s; bit period DIV = round(CLK_HZ/BAUD_HZ) cycles; DIV >= 2 is required
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
tx_valid  input  1  producer has a word on tx_data
tx_data  input  DATA_BITS  word to send, LSB first on the line
tx_ready  output  1  block can accept a word this cycle
tx_busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on the last cycle of the last stop bit
tx  output  1  serial line, idle high

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst.
- While rst is asserted: tx=1, tx_ready=0, tx_busy=0, frame_done=0, state=IDLE, timer=0, bit counter=0.
- After rst deasserts: tx_ready=1 from the first clock edge.
- All outputs are registered.
- States:
  - IDLE: tx=1, tx_ready=1.
  - START: tx=0.
  - DATA: shift register LSB drives tx.
  - PARITY: skipped entirely when PARITY=0.
  - STOP: tx=1, lasts STOP_BITS*DIV cycles.
- Accept: transfer occurs on a cycle with tx_valid && tx_ready. On that cycle tx_data is latched into the shift register and the parity bit is computed. Next cycle: state=START, tx=0, tx_busy=1, tx_ready=0.
- Input during a frame: tx_data and tx_valid are ignored while busy. A later change to tx_data does not affect the frame in flight.
- Bit timer: counts 0..DIV-1 and restarts at 0 on accept, so the start-bit edge is phase-aligned to the accept. Each bit holds exactly DIV cycles. The state advances when the timer reaches DIV-1.
- DATA: the bit counter runs 0..DATA_BITS-1 and the shift register shifts right once per bit.
- Parity: even parity = XOR of the data bits; odd parity = its inverse. Computed over DATA_BITS bits only.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- End of frame:
  - frame_done=1 on the final STOP cycle.
  - Next cycle: IDLE, tx_busy=0, tx_ready=1.
  - Minimum inter-frame gap is therefore 1 idle cycle (tx=1) when tx_valid is held continuously.
- Reset mid-frame: tx goes high immediately (asynchronously). The frame is abandoned and no frame_done is produced.
- Parameter errors: illegal values (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS outside {1,2}, DIV < 2) stop elaboration with an error.

Decomposition:
- Shared package uart_pkg:
  - parity encoding constants PAR_NONE / PAR_ODD / PAR_EVEN
  - state encoding IDLE / START / DATA / PARITY / STOP
  - constant function for DIV and the timer width clog2(DIV)
- Sub-module uart_bit_timer:
  - ports: clk, rst, restart, bit_end pulse
  - parameter: DIV
  - the FSM restarts it on accept.
- Sub-module choice: this replaces the free-running divider. It is the only natural split; the FSM, shift register and parity logic stay in uart_tx_cfg.

Test Plan:
All scenarios use CLK_HZ=1_000_000 and BAUD_HZ=100_000, so DIV=10.
1. 8N1, send 0x55:
   - tx=0 for 10 cycles, then bits 1,0,1,0,1,0,1,0 for 10 cycles each, then stop high for 10 cycles.
   - frame_done at cycle 100 after accept; tx_ready back high at cycle 101.
2. 8E1, send 0x07:
   - parity bit = 1 at cycles 91–100.
   - frame length 110 cycles.
   - Repeat with 8O1: parity bit = 0.
3. 7N2 (DATA_BITS=7, STOP_BITS=2), send 0x7F:
   - 7 data bits high, then 20 stop cycles high.
   - frame_done at cycle 100.
   - tx_data bit 7 is not present on the port.
4. Back-to-back, tx_valid held with 0xA5 then 0x3C:
   - the second start bit begins exactly 1 cycle after frame_done of the first.
   - a mid-frame change of tx_data to 0xFF does not alter the serialized 0xA5.
5. Reset mid-frame:
   - assert rst at cycle 35 of a 0x00 frame: tx=1 in the same cycle (before the next clk edge); no frame_done.
   - after release, tx_ready=1 and a new 0x81 frame transmits correctly.
6. Handshake idle check:
   - tx_valid=0 for 50 cycles: tx stays 1, tx_busy stays 0, tx_ready stays 1, no frame_done.
